diff_commit_checker: RTL



---
 rtl/diff_commit_checker_pkg.sv | 32 +++
 rtl/diff_shadow_gpr.sv | 74 +++++++
 rtl/diff_commit_checker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/diff_commit_checker_pkg.sv
`default_nettype none
// ============================================================================
// diff_commit_checker_pkg : shared difftest types, error codes, GPR helpers
// Revision : 1.0
// ============================================================================
package diff_commit_checker_pkg;

    localparam int GPR_W      = 64;
    localparam int NGPR       = 32;
    localparam int GPR_FLAT_W = GPR_W * NGPR;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_GPR     = 3'd1,
        ERR_ORDER   = 3'd2,
        ERR_WDEST   = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_code_e;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } chk_state_e;

    function automatic logic [GPR_W-1:0] gpr_slice(input logic [GPR_FLAT_W-1:0] flat,
                                                   input int idx);
        return flat[GPR_W*idx +: GPR_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/diff_shadow_gpr.sv
`default_nettype none
// ============================================================================
// diff_shadow_gpr : commit-rebuilt GPR file with first-mismatch encoder
// Revision : 1.0
// ============================================================================
module diff_shadow_gpr
    import diff_commit_checker_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic                  valid_0,
    input  logic                  wen_0,
    input  logic [7:0]            wdest_0,
    input  logic [GPR_W-1:0]      wdata_0,
    input  logic                  valid_1,
    input  logic                  wen_1,
    input  logic [7:0]            wdest_1,
    input  logic [GPR_W-1:0]      wdata_1,
    input  logic [GPR_FLAT_W-1:0] gpr_state,
    output logic [GPR_FLAT_W-1:0] shadow_flat,
    output logic                  mm_valid,
    output logic [4:0]            mm_idx,
    output logic [GPR_W-1:0]      mm_expect,
    output logic [GPR_W-1:0]      mm_actual
);

    logic w_we_0;
    logic w_we_1;
    logic w_unused_r0;

    assign w_we_0 = wr_en & valid_0 & wen_0 & (wdest_0[7:5] == 3'd0) & (wdest_0[4:0] != 5'd0);
    assign w_we_1 = wr_en & valid_1 & wen_1 & (wdest_1[7:5] == 3'd0) & (wdest_1[4:0] != 5'd0);

    assign shadow_flat[GPR_W-1:0] = '0;
    assign w_unused_r0            = ^gpr_state[GPR_W-1:0];

    // Lane 1 is younger, so its write takes precedence on a shared destination.
    generate
        for (genvar i = 1; i < NGPR; i++) begin : g_gpr
            logic [GPR_W-1:0] r_val;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    r_val <= '0;
                end else if (w_we_1 && (wdest_1[4:0] == 5'(i))) begin
                    r_val <= wdata_1;
                end else if (w_we_0 && (wdest_0[4:0] == 5'(i))) begin
                    r_val <= wdata_0;
                end
            end

            assign shadow_flat[GPR_W*i +: GPR_W] = r_val;
        end
    endgenerate

    // Scan from the top so the lowest mismatching index is what remains.
    always_comb begin
        mm_valid  = 1'b0;
        mm_idx    = 5'd0;
        mm_expect = '0;
        mm_actual = '0;
        for (int i = NGPR - 1; i >= 1; i--) begin
            if (gpr_slice(shadow_flat, i) != gpr_slice(gpr_state, i)) begin
                mm_valid  = 1'b1;
                mm_idx    = 5'(i);
                mm_expect = gpr_slice(shadow_flat, i);
                mm_actual = gpr_slice(gpr_state, i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/diff_commit_checker.sv
`default_nettype none
// ============================================================================
// diff_commit_checker : on-chip dual-lane difftest commit self-checker
// Revision : 1.0
// ============================================================================
module diff_commit_checker
    import diff_commit_checker_pkg::*;
#(
    parameter int TIMEOUT = 65536,
    parameter int CNT_W   = 64
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  commit_valid_0,
    input  logic [63:0]           commit_pc_0,
    input  logic [31:0]           commit_instr_0,
    input  logic                  commit_wen_0,
    input  logic [7:0]            commit_wdest_0,
    input  logic [63:0]           commit_wdata_0,
    input  logic                  commit_valid_1,
    input  logic [63:0]           commit_pc_1,
    input  logic [31:0]           commit_instr_1,
    input  logic                  commit_wen_1,
    input  logic [7:0]            commit_wdest_1,
    input  logic [63:0]           commit_wdata_1,
    input  logic [GPR_FLAT_W-1:0] gpr_state,
    output logic                  halted,
    output logic [2:0]            err_code,
    output logic [63:0]           err_pc,
    output logic [31:0]           err_instr,
    output logic [4:0]            err_gpr,
    output logic [63:0]           err_expect,
    output logic [63:0]           err_actual,
    output logic [CNT_W-1:0]      instr_cnt,
    output logic [CNT_W-1:0]      cycle_cnt
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    chk_state_e             r_state;
    chk_state_e             w_state_next;
    err_code_e              w_err;
    err_code_e              r_err_code;
    logic [63:0]            w_err_pc;
    logic [31:0]            w_err_instr;
    logic                   r_halted;
    logic [63:0]            r_err_pc;
    logic [31:0]            r_err_instr;
    logic [4:0]             r_err_gpr;
    logic [63:0]            r_err_expect;
    logic [63:0]            r_err_actual;
    logic [CNT_W-1:0]       r_instr_cnt;
    logic [CNT_W-1:0]       r_cycle_cnt;
    logic [IDLE_W-1:0]      r_idle;
    logic [IDLE_W-1:0]      w_idle_inc;
    logic [63:0]            r_last_pc;
    logic [31:0]            r_last_instr;

    logic                   w_active;
    logic                   w_run;
    logic                   w_count;
    logic                   w_any;
    logic                   w_bad_0;
    logic                   w_bad_1;
    logic                   w_mm_valid;
    logic [4:0]             w_mm_idx;
    logic [63:0]            w_mm_expect;
    logic [63:0]            w_mm_actual;
    logic [GPR_FLAT_W-1:0]  w_unused_shadow;

    assign w_active   = (r_state != ST_ERROR);
    assign w_run      = (r_state == ST_RUN);
    assign w_count    = w_run | ((r_state == ST_WAIT) & commit_valid_0);
    assign w_any      = commit_valid_0 | commit_valid_1;
    assign w_bad_0    = commit_valid_0 & commit_wen_0 & (commit_wdest_0[7:5] != 3'd0);
    assign w_bad_1    = commit_valid_1 & commit_wen_1 & (commit_wdest_1[7:5] != 3'd0);
    assign w_idle_inc = r_idle + IDLE_W'(1);

    diff_shadow_gpr u_shadow (
        .clock       (clock),
        .resetn      (resetn),
        .wr_en       (w_active),
        .valid_0     (commit_valid_0),
        .wen_0       (commit_wen_0),
        .wdest_0     (commit_wdest_0),
        .wdata_0     (commit_wdata_0),
        .valid_1     (commit_valid_1),
        .wen_1       (commit_wen_1),
        .wdest_1     (commit_wdest_1),
        .wdata_1     (commit_wdata_1),
        .gpr_state   (gpr_state),
        .shadow_flat (w_unused_shadow),
        .mm_valid    (w_mm_valid),
        .mm_idx      (w_mm_idx),
        .mm_expect   (w_mm_expect),
        .mm_actual   (w_mm_actual)
    );

    always_comb begin
        w_state_next = r_state;
        w_err        = ERR_NONE;
        w_err_pc     = '0;
        w_err_instr  = '0;
        case (r_state)
            ST_WAIT: begin
                if (commit_valid_0) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (commit_valid_1 && !commit_valid_0) begin
                    w_err       = ERR_ORDER;
                    w_err_pc    = commit_pc_1;
                    w_err_instr = commit_instr_1;
                end else if (w_bad_0) begin
                    w_err       = ERR_WDEST;
                    w_err_pc    = commit_pc_0;
                    w_err_instr = commit_instr_0;
                end else if (w_bad_1) begin
                    w_err       = ERR_WDEST;
                    w_err_pc    = commit_pc_1;
                    w_err_instr = commit_instr_1;
                end else if (w_mm_valid) begin
                    w_err       = ERR_GPR;
                    w_err_pc    = r_last_pc;
                    w_err_instr = r_last_instr;
                end else if (!w_any && (w_idle_inc >= IDLE_W'(TIMEOUT))) begin
                    w_err       = ERR_TIMEOUT;
                    w_err_pc    = r_last_pc;
                    w_err_instr = r_last_instr;
                end
                if (w_err != ERR_NONE) begin
                    w_state_next = ST_ERROR;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_WAIT;
            r_halted     <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_pc     <= '0;
            r_err_instr  <= '0;
            r_err_gpr    <= '0;
            r_err_expect <= '0;
            r_err_actual <= '0;
            r_instr_cnt  <= '0;
            r_cycle_cnt  <= '0;
            r_idle       <= '0;
            r_last_pc    <= '0;
            r_last_instr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_err != ERR_NONE) begin
                r_halted    <= 1'b1;
                r_err_code  <= w_err;
                r_err_pc    <= w_err_pc;
                r_err_instr <= w_err_instr;
                if (w_err == ERR_GPR) begin
                    r_err_gpr    <= w_mm_idx;
                    r_err_expect <= w_mm_expect;
                    r_err_actual <= w_mm_actual;
                end
            end
            // The detecting cycle's commits still land; only later cycles are frozen.
            if (w_active) begin
                if (commit_valid_1) begin
                    r_last_pc    <= commit_pc_1;
                    r_last_instr <= commit_instr_1;
                end else if (commit_valid_0) begin
                    r_last_pc    <= commit_pc_0;
                    r_last_instr <= commit_instr_0;
                end
            end
            if (w_count) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(commit_valid_0) + CNT_W'(commit_valid_1);
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_run) begin
                r_idle <= w_any ? '0 : w_idle_inc;
            end
        end
    end

    assign halted     = r_halted;
    assign err_code   = r_err_code;
    assign err_pc     = r_err_pc;
    assign err_instr  = r_err_instr;
    assign err_gpr    = r_err_gpr;
    assign err_expect = r_err_expect;
    assign err_actual = r_err_actual;
    assign instr_cnt  = r_instr_cnt;
    assign cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire
